// File: rtl/pc_seq.sv
// Program-counter sequencer for a 12-bit-instruction core: branch decode, flush slot
// and a two-level return stack with sticky overflow/underflow flags.
module pc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] instr,
  input  logic [8:0]  pc_cur,
  input  logic        skip,
  input  logic        pcl_wr,
  input  logic [7:0]  alu_pcl,
  input  logic        clr_err,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [8:0]  pc_mux_in,
  output logic        flush,
  output logic [1:0]  stk_depth,
  output logic        stk_ovf,
  output logic        stk_unf
);

  typedef enum logic {StExec, StFlush} state_e;

  state_e      state_q, state_d;
  logic [8:0]  s1_q, s2_q;
  logic [1:0]  depth_q;
  logic        ovf_q, unf_q;
  logic        push, pop;

  logic is_retlw, is_call, is_goto;
  assign is_retlw = (instr[11:8] == 4'b1000);
  assign is_call  = (instr[11:8] == 4'b1001);
  assign is_goto  = (instr[11:9] == 3'b101);

  // Outputs are gated by rst so they read zero for the whole reset interval.
  always_comb begin
    state_d   = state_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_mux_in = 9'h000;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (rst && en) begin
      case (state_q)
        StExec: begin
          if (is_retlw) begin
            pc_load   = 1'b1;
            pc_mux_in = s1_q;
            pop       = 1'b1;
            state_d   = StFlush;
          end else if (is_call) begin
            pc_load   = 1'b1;
            pc_mux_in = {1'b0, instr[7:0]};
            push      = 1'b1;
            state_d   = StFlush;
          end else if (is_goto) begin
            pc_load   = 1'b1;
            pc_mux_in = instr[8:0];
            state_d   = StFlush;
          end else if (pcl_wr) begin
            pc_load   = 1'b1;
            pc_mux_in = {1'b0, alu_pcl};
            state_d   = StFlush;
          end else if (skip) begin
            pc_inc  = 1'b1;
            state_d = StFlush;
          end else begin
            pc_inc = 1'b1;
          end
        end
        StFlush: begin
          flush   = 1'b1;
          pc_inc  = 1'b1;
          state_d = StExec;
        end
        default: state_d = StExec;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StExec;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Stack: s1 is top of stack; a pop on empty still returns s1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 9'h000;
      s2_q    <= 9'h000;
      depth_q <= 2'd0;
    end else if (push) begin
      s2_q    <= s1_q;
      s1_q    <= pc_cur + 9'd1;
      depth_q <= (depth_q == 2'd2) ? 2'd2 : depth_q + 2'd1;
    end else if (pop) begin
      s1_q    <= s2_q;
      depth_q <= (depth_q == 2'd0) ? 2'd0 : depth_q - 2'd1;
    end
  end

  // A new error in the same cycle as clr_err takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (en) begin
      if (push && depth_q == 2'd2) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
      if (pop && depth_q == 2'd0) begin
        unf_q <= 1'b1;
      end else if (clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign stk_depth = depth_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: each step's expected outputs are queued as it is driven
// and popped when the DUT is sampled at the falling edge.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst, en, skip, pcl_wr, clr_err;
  logic [11:0] instr;
  logic [8:0]  pc_cur;
  logic [7:0]  alu_pcl;
  logic        pc_inc, pc_load, flush, stk_ovf, stk_unf;
  logic [8:0]  pc_mux_in;
  logic [1:0]  stk_depth;

  int n_cmp = 0;
  int n_err = 0;

  pc_seq dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr), .pc_cur(pc_cur), .skip(skip),
    .pcl_wr(pcl_wr), .alu_pcl(alu_pcl), .clr_err(clr_err), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_mux_in(pc_mux_in), .flush(flush), .stk_depth(stk_depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [11:0] instr;
    logic [8:0]  pc;
    logic        skip, pcl_wr;
    logic [7:0]  alu;
    logic        clr;
    logic [11:0] out;    // {pc_inc, pc_load, flush, pc_mux_in} during the cycle
    logic [1:0]  depth;  // stack state after the edge
    logic        ovf, unf;
  } step_t;

  step_t plan[$];
  step_t sb[$];

  localparam logic [11:0] ZERO = 12'h000;
  localparam logic [11:0] INC  = 12'h800;
  localparam logic [11:0] FL   = 12'hA00;
  localparam logic [11:0] NOP  = 12'h000;

  function automatic logic [11:0] ld(input logic [8:0] m);
    return {3'b010, m};
  endfunction

  function automatic logic [11:0] call_op(input logic [7:0] k);
    return {4'b1001, k};
  endfunction

  function automatic logic [11:0] retlw_op(input logic [7:0] k);
    return {4'b1000, k};
  endfunction

  function automatic void add(input logic e, input logic [11:0] i, input logic [8:0] pc,
                              input logic sk, input logic pw, input logic [7:0] a,
                              input logic c, input logic [11:0] o, input logic [1:0] d,
                              input logic ov, input logic un);
    step_t s;
    s.en = e; s.instr = i; s.pc = pc; s.skip = sk; s.pcl_wr = pw; s.alu = a; s.clr = c;
    s.out = o; s.depth = d; s.ovf = ov; s.unf = un;
    plan.push_back(s);
  endfunction

  task automatic idle();
    en = 1'b0; instr = NOP; pc_cur = 9'h000; skip = 1'b0; pcl_wr = 1'b0;
    alu_pcl = 8'h00; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; instr = 12'hBA3; skip = 1'b1; pcl_wr = 1'b1; alu_pcl = 8'h55;
    pc_cur = 9'h005; clr_err = 1'b0;
    #3;
    n_cmp++;
    if ({pc_inc, pc_load, flush, pc_mux_in} !== ZERO) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", {pc_inc, pc_load, flush, pc_mux_in}, ZERO);
    end
    n_cmp++;
    if ({stk_depth, stk_ovf, stk_unf} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_stack: got %b want 0000", {stk_depth, stk_ovf, stk_unf});
    end
    idle();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_goto();
    step_t e, s;
    add(1, 12'hBA3, 9'h005, 0, 0, 8'h00, 0, ld(9'h1A3), 2'd0, 0, 0);
    add(1, 12'hBA3, 9'h006, 1, 1, 8'h77, 0, FL, 2'd0, 0, 0);
    add(1, NOP, 9'h1A3, 0, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    // Higher-priority GOTO beats skip and pcl_wr
    add(1, 12'hA21, 9'h1A4, 1, 1, 8'h33, 0, ld(9'h021), 2'd0, 0, 0);
    add(1, NOP, 9'h1A5, 0, 0, 8'h00, 0, FL, 2'd0, 0, 0);
    for (int k = 0; plan.size() > 0; k++) begin
      s = plan.pop_front();
      en = s.en; instr = s.instr; pc_cur = s.pc; skip = s.skip; pcl_wr = s.pcl_wr;
      alu_pcl = s.alu; clr_err = s.clr;
      sb.push_back(s);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_inc, pc_load, flush, pc_mux_in} !== e.out) begin
        n_err++;
        $display("FAIL goto[%0d] outputs: got %h want %h", k,
                 {pc_inc, pc_load, flush, pc_mux_in}, e.out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_depth, stk_ovf, stk_unf} !== {e.depth, e.ovf, e.unf}) begin
        n_err++;
        $display("FAIL goto[%0d] stack: got %b want %b", k, {stk_depth, stk_ovf, stk_unf},
                 {e.depth, e.ovf, e.unf});
      end
    end
    idle();
  endtask

  task automatic test_call_stack();
    step_t e, s;
    add(1, call_op(8'h40), 9'h010, 0, 0, 8'h00, 0, ld(9'h040), 2'd1, 0, 0);
    add(1, NOP, 9'h011, 0, 0, 8'h00, 0, FL, 2'd1, 0, 0);
    add(1, retlw_op(8'hAB), 9'h040, 0, 0, 8'h00, 0, ld(9'h011), 2'd0, 0, 0);
    add(1, NOP, 9'h041, 0, 0, 8'h00, 0, FL, 2'd0, 0, 0);
    // Three calls overflow; pops then walk s1 <- s2 with s2 left in place
    add(1, call_op(8'h00), 9'h001, 0, 0, 8'h00, 0, ld(9'h000), 2'd1, 0, 0);
    add(1, NOP, 9'h002, 0, 0, 8'h00, 0, FL, 2'd1, 0, 0);
    add(1, call_op(8'h10), 9'h101, 0, 0, 8'h00, 0, ld(9'h010), 2'd2, 0, 0);
    add(1, NOP, 9'h102, 0, 0, 8'h00, 0, FL, 2'd2, 0, 0);
    add(1, call_op(8'h20), 9'h0FF, 0, 0, 8'h00, 0, ld(9'h020), 2'd2, 1, 0);
    add(1, NOP, 9'h100, 0, 0, 8'h00, 0, FL, 2'd2, 1, 0);
    add(1, retlw_op(8'h00), 9'h020, 0, 0, 8'h00, 0, ld(9'h100), 2'd1, 1, 0);
    add(1, NOP, 9'h021, 0, 0, 8'h00, 0, FL, 2'd1, 1, 0);
    add(1, retlw_op(8'h00), 9'h100, 0, 0, 8'h00, 0, ld(9'h102), 2'd0, 1, 0);
    add(1, NOP, 9'h101, 0, 0, 8'h00, 0, FL, 2'd0, 1, 0);
    add(1, retlw_op(8'h00), 9'h102, 0, 0, 8'h00, 0, ld(9'h102), 2'd0, 1, 1);
    add(1, NOP, 9'h103, 0, 0, 8'h00, 0, FL, 2'd0, 1, 1);
    // clr_err is ignored while stalled
    add(0, NOP, 9'h103, 0, 0, 8'h00, 1, ZERO, 2'd0, 1, 1);
    // New underflow in the clearing cycle wins; overflow clears
    add(1, retlw_op(8'h00), 9'h103, 0, 0, 8'h00, 1, ld(9'h102), 2'd0, 0, 1);
    add(1, NOP, 9'h104, 0, 0, 8'h00, 0, FL, 2'd0, 0, 1);
    add(1, NOP, 9'h105, 0, 0, 8'h00, 1, INC, 2'd0, 0, 0);
    // Return address wraps at the top of program memory
    add(1, call_op(8'h55), 9'h1FF, 0, 0, 8'h00, 0, ld(9'h055), 2'd1, 0, 0);
    add(1, NOP, 9'h000, 0, 0, 8'h00, 0, FL, 2'd1, 0, 0);
    add(1, retlw_op(8'h00), 9'h055, 0, 0, 8'h00, 0, ld(9'h000), 2'd0, 0, 0);
    add(1, NOP, 9'h056, 0, 0, 8'h00, 0, FL, 2'd0, 0, 0);
    for (int k = 0; plan.size() > 0; k++) begin
      s = plan.pop_front();
      en = s.en; instr = s.instr; pc_cur = s.pc; skip = s.skip; pcl_wr = s.pcl_wr;
      alu_pcl = s.alu; clr_err = s.clr;
      sb.push_back(s);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_inc, pc_load, flush, pc_mux_in} !== e.out) begin
        n_err++;
        $display("FAIL call_stack[%0d] outputs: got %h want %h", k,
                 {pc_inc, pc_load, flush, pc_mux_in}, e.out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_depth, stk_ovf, stk_unf} !== {e.depth, e.ovf, e.unf}) begin
        n_err++;
        $display("FAIL call_stack[%0d] stack: got %b want %b", k, {stk_depth, stk_ovf, stk_unf},
                 {e.depth, e.ovf, e.unf});
      end
    end
    idle();
  endtask

  task automatic test_skip_pcl();
    step_t e, s;
    add(1, NOP, 9'h030, 1, 1, 8'h80, 0, ld(9'h080), 2'd0, 0, 0);
    add(1, NOP, 9'h031, 1, 1, 8'h44, 0, FL, 2'd0, 0, 0);
    add(1, NOP, 9'h080, 1, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    add(1, NOP, 9'h081, 0, 0, 8'h00, 0, FL, 2'd0, 0, 0);
    add(1, NOP, 9'h082, 0, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    add(1, NOP, 9'h083, 0, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    for (int k = 0; plan.size() > 0; k++) begin
      s = plan.pop_front();
      en = s.en; instr = s.instr; pc_cur = s.pc; skip = s.skip; pcl_wr = s.pcl_wr;
      alu_pcl = s.alu; clr_err = s.clr;
      sb.push_back(s);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_inc, pc_load, flush, pc_mux_in} !== e.out) begin
        n_err++;
        $display("FAIL skip_pcl[%0d] outputs: got %h want %h", k,
                 {pc_inc, pc_load, flush, pc_mux_in}, e.out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_depth, stk_ovf, stk_unf} !== {e.depth, e.ovf, e.unf}) begin
        n_err++;
        $display("FAIL skip_pcl[%0d] stack: got %b want %b", k, {stk_depth, stk_ovf, stk_unf},
                 {e.depth, e.ovf, e.unf});
      end
    end
    idle();
  endtask

  task automatic test_stall_reset();
    step_t e, s;
    add(1, 12'hBA3, 9'h005, 0, 0, 8'h00, 0, ld(9'h1A3), 2'd0, 0, 0);
    add(0, NOP, 9'h1A3, 0, 0, 8'h00, 0, ZERO, 2'd0, 0, 0);
    add(0, call_op(8'h12), 9'h1A3, 1, 1, 8'h00, 0, ZERO, 2'd0, 0, 0);
    add(0, NOP, 9'h1A3, 0, 0, 8'h00, 0, ZERO, 2'd0, 0, 0);
    add(1, NOP, 9'h1A3, 0, 0, 8'h00, 0, FL, 2'd0, 0, 0);
    add(1, NOP, 9'h1A4, 0, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    add(1, call_op(8'h60), 9'h010, 0, 0, 8'h00, 0, ld(9'h060), 2'd1, 0, 0);
    for (int k = 0; plan.size() > 0; k++) begin
      s = plan.pop_front();
      en = s.en; instr = s.instr; pc_cur = s.pc; skip = s.skip; pcl_wr = s.pcl_wr;
      alu_pcl = s.alu; clr_err = s.clr;
      sb.push_back(s);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_inc, pc_load, flush, pc_mux_in} !== e.out) begin
        n_err++;
        $display("FAIL stall[%0d] outputs: got %h want %h", k,
                 {pc_inc, pc_load, flush, pc_mux_in}, e.out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_depth, stk_ovf, stk_unf} !== {e.depth, e.ovf, e.unf}) begin
        n_err++;
        $display("FAIL stall[%0d] stack: got %b want %b", k, {stk_depth, stk_ovf, stk_unf},
                 {e.depth, e.ovf, e.unf});
      end
    end
    // Now in the flush slot: reset mid-cycle must kill outputs and the stack
    en = 1'b1; instr = NOP; rst = 1'b0;
    #1;
    n_cmp++;
    if ({pc_inc, pc_load, flush, pc_mux_in} !== ZERO) begin
      n_err++;
      $display("FAIL midflush_reset outputs: got %h want %h", {pc_inc, pc_load, flush, pc_mux_in},
               ZERO);
    end
    n_cmp++;
    if (stk_depth !== 2'd0) begin
      n_err++;
      $display("FAIL midflush_reset depth: got %0d want 0", stk_depth);
    end
    idle();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    add(1, NOP, 9'h000, 0, 0, 8'h00, 0, INC, 2'd0, 0, 0);
    add(1, retlw_op(8'h00), 9'h001, 0, 0, 8'h00, 0, ld(9'h000), 2'd0, 0, 1);
    add(1, NOP, 9'h002, 0, 0, 8'h00, 0, FL, 2'd0, 0, 1);
    for (int k = 0; plan.size() > 0; k++) begin
      s = plan.pop_front();
      en = s.en; instr = s.instr; pc_cur = s.pc; skip = s.skip; pcl_wr = s.pcl_wr;
      alu_pcl = s.alu; clr_err = s.clr;
      sb.push_back(s);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_inc, pc_load, flush, pc_mux_in} !== e.out) begin
        n_err++;
        $display("FAIL post_reset[%0d] outputs: got %h want %h", k,
                 {pc_inc, pc_load, flush, pc_mux_in}, e.out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_depth, stk_ovf, stk_unf} !== {e.depth, e.ovf, e.unf}) begin
        n_err++;
        $display("FAIL post_reset[%0d] stack: got %b want %b", k, {stk_depth, stk_ovf, stk_unf},
                 {e.depth, e.ovf, e.unf});
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_goto();
    test_call_stack();
    test_skip_pcl();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
